// File: rtl/dmem_responder.sv
// dmem_responder
// Word-addressed data-memory responder for the core's load/store port.
// One request at a time is taken over a valid/ready handshake, held for
// WAIT_STATES cycles, then answered over a second valid/ready handshake.
// Misaligned or out-of-window addresses are answered with rsp_err=1 and
// never touch storage.
//
// Ports:
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder idle and able to take a request
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     store byte enables, bit i covers bits [8i+7:8i]
//   rsp_valid  response present
//   rsp_ready  requester takes the response
//   rsp_rdata  load data (0 for stores and errors)
//   rsp_err    access error flag
//
// state  | meaning
// S_IDLE | waiting for a request, req_ready=1
// S_WAIT | counting wait states down to zero
// S_RESP | response presented until rsp_ready

module dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t       r_state;
    state_t       w_next;
    logic [3:0]   r_cnt;
    logic [3:0]   w_cnt_next;

    logic         r_we;
    logic [31:0]  r_addr;
    logic [31:0]  r_wdata;
    logic [3:0]   r_be;
    logic [31:0]  r_rdata;
    logic         r_err;

    logic [31:0]  r_mem [DEPTH];

    logic         w_accept;
    logic         w_enter_resp;
    logic         w_we;
    logic [31:0]  w_addr;
    logic [31:0]  w_wdata;
    logic [3:0]   w_be;
    logic [32:0]  w_addr_x;
    logic [32:0]  w_lo;
    logic [32:0]  w_hi;
    logic         w_err;
    logic [31:0]  w_off;
    logic [AW-1:0] w_idx;
    logic         w_store;

    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

    assign w_accept     = req_valid & req_ready;
    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    // With zero wait states RESP is entered on the accepting edge itself,
    // before the request registers are loaded, so the live inputs are used.
    assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
    assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
    assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
    assign w_be    = (r_state == S_IDLE) ? req_be    : r_be;

    // 33-bit window compare so BASE_ADDR + DEPTH*4 cannot wrap to zero.
    assign w_addr_x = {1'b0, w_addr};
    assign w_lo     = {1'b0, BASE_ADDR};
    assign w_hi     = w_lo + (33'(DEPTH) << 2);
    assign w_err    = (w_addr[1:0] != 2'b00) | (w_addr_x < w_lo) | (w_addr_x >= w_hi);

    assign w_off = w_addr - BASE_ADDR;
    assign w_idx = AW'(w_off >> 2);

    // Gated by rstn so nothing commits on an edge seen while reset is held.
    assign w_store = w_enter_resp & w_we & ~w_err & rstn;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = 4'(WAIT_STATES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_be    <= 4'd0;
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_we    <= req_we;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_be    <= req_be;
            end
            if (w_enter_resp) begin
                r_err   <= w_err;
                r_rdata <= (w_we || w_err) ? 32'd0 : r_mem[w_idx];
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_store) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses WAIT_STATES=2, DEPTH=256,
// BASE=0; instance 1 uses WAIT_STATES=0, DEPTH=16, BASE=0x1000.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    logic [31:0] mm [2][256];
    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(256), .WAIT_STATES(2), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(16), .WAIT_STATES(0), .BASE_ADDR(32'h0000_1000)) dut1 (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic longint dep_of(input int d);
        return (d == 0) ? 256 : 16;
    endfunction

    function automatic longint base_of(input int d);
        return (d == 0) ? 64'h0 : 64'h1000;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 0) ? 2 : 0;
    endfunction

    // One complete transaction on instance d, checked against the model.
    task automatic do_req(input int d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] be, input int hold,
                          output logic [31:0] got_rd, output logic got_err);
        longint a, b, top;
        int idx, lat;
        bit exp_err;
        logic [31:0] exp_rd;
        a = longint'(addr);
        b = base_of(d);
        top = b + dep_of(d) * 4;
        exp_err = (addr[1:0] != 2'b00) || (a < b) || (a >= top);
        idx = exp_err ? 0 : int'((a - b) / 4);
        exp_rd = (!exp_err && !we) ? mm[d][idx] : 32'd0;

        @(negedge clk);
        n_chk++;
        if (req_ready[d] !== 1'b1) $display("FAIL req_ready_idle d=%0d: got %b expected 1", d, req_ready[d]);
        else n_pass++;
        req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = addr;
        req_wdata[d] = wd; req_be[d] = be; rsp_ready[d] = 1'b0;

        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            req_valid[d] = 1'b0;
            req_addr[d] = $urandom;
            if (rsp_valid[d] === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_chk++;
        if (lat != ws_of(d) + 1) $display("FAIL latency d=%0d addr=%h: got %0d expected %0d", d, addr, lat, ws_of(d) + 1);
        else n_pass++;

        if (we && !exp_err)
            for (int i = 0; i < 4; i++)
                if (be[i]) mm[d][idx][8*i +: 8] = wd[8*i +: 8];

        got_rd = rsp_rdata[d];
        got_err = rsp_err[d];
        n_chk++;
        if (rsp_rdata[d] !== exp_rd) $display("FAIL rdata d=%0d addr=%h: got %h expected %h", d, addr, rsp_rdata[d], exp_rd);
        else n_pass++;
        n_chk++;
        if (rsp_err[d] !== exp_err) $display("FAIL err d=%0d addr=%h: got %b expected %b", d, addr, rsp_err[d], exp_err);
        else n_pass++;

        for (int h = 0; h < hold; h++) begin
            req_valid[d] = 1'b1;
            @(negedge clk);
            n_chk++;
            if (rsp_valid[d] !== 1'b1 || rsp_rdata[d] !== exp_rd || rsp_err[d] !== exp_err || req_ready[d] !== 1'b0)
                $display("FAIL hold_stable d=%0d cyc=%0d: got v=%b rd=%h e=%b rdy=%b expected v=1 rd=%h e=%b rdy=0",
                         d, h, rsp_valid[d], rsp_rdata[d], rsp_err[d], req_ready[d], exp_rd, exp_err);
            else n_pass++;
        end
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b1;
        @(negedge clk);
        n_chk++;
        if (rsp_valid[d] !== 1'b0 || req_ready[d] !== 1'b1)
            $display("FAIL complete d=%0d: got v=%b rdy=%b expected v=0 rdy=1", d, rsp_valid[d], req_ready[d]);
        else n_pass++;
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_chk++;
            if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0 || rsp_rdata[d] !== 32'd0 || rsp_err[d] !== 1'b0)
                $display("FAIL reset d=%0d: got rdy=%b v=%b rd=%h e=%b expected 1 0 0 0",
                         d, req_ready[d], rsp_valid[d], rsp_rdata[d], rsp_err[d]);
            else n_pass++;
        end
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_prefill;
        logic [31:0] rd; logic e;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < int'(dep_of(d)); i++)
                do_req(d, 1'b1, 32'(base_of(d) + 4 * i), $urandom, 4'hF, 0, rd, e);
    endtask

    task automatic test_store_load;
        logic [31:0] rd; logic e;
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, e);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e);
        n_chk++;
        if (rd !== 32'hDEADBEEF) $display("FAIL store_load: got %h expected deadbeef", rd);
        else n_pass++;
    endtask

    task automatic test_partial;
        logic [31:0] rd; logic e;
        do_req(0, 1'b1, 32'h10, 32'h0000_1234, 4'b0011, 0, rd, e);
        do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, 0, rd, e);
        n_chk++;
        if (rd !== 32'hDEAD1234) $display("FAIL partial_store: got %h expected dead1234", rd);
        else n_pass++;
    endtask

    task automatic test_errors;
        logic [31:0] rd, old; logic e;
        do_req(0, 1'b0, 32'h13, 32'h0, 4'hF, 0, rd, e);
        n_chk++;
        if (e !== 1'b1 || rd !== 32'd0) $display("FAIL misaligned: got e=%b rd=%h expected e=1 rd=0", e, rd);
        else n_pass++;
        old = mm[0][255];
        do_req(0, 1'b1, 32'h400, 32'hA5A5_A5A5, 4'hF, 0, rd, e);
        n_chk++;
        if (e !== 1'b1) $display("FAIL out_of_range: got e=%b expected 1", e);
        else n_pass++;
        do_req(0, 1'b0, 32'h3FC, 32'h0, 4'hF, 0, rd, e);
        n_chk++;
        if (rd !== old) $display("FAIL last_word_kept: got %h expected %h", rd, old);
        else n_pass++;
    endtask

    task automatic test_hold;
        logic [31:0] rd; logic e;
        do_req(0, 1'b0, 32'h10, 32'h0, 4'hF, 5, rd, e);
        do_req(0, 1'b0, 32'h7, 32'h0, 4'hF, 5, rd, e);
    endtask

    task automatic test_reset_mid_wait;
        logic [31:0] rd, old; logic e;
        old = mm[0][5];
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h14;
        req_wdata[0] = ~old; req_be[0] = 4'hF;
        @(negedge clk);
        req_valid[0] = 1'b0;
        n_chk++;
        if (req_ready[0] !== 1'b0) $display("FAIL in_wait: got rdy=%b expected 0", req_ready[0]);
        else n_pass++;
        rstn = 1'b0;
        #1;
        n_chk++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0 || rsp_rdata[0] !== 32'd0 || rsp_err[0] !== 1'b0)
            $display("FAIL async_reset: got rdy=%b v=%b rd=%h e=%b expected 1 0 0 0",
                     req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0]);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        do_req(0, 1'b0, 32'h14, 32'h0, 4'hF, 0, rd, e);
        n_chk++;
        if (rd !== old) $display("FAIL dropped_store: got %h expected %h", rd, old);
        else n_pass++;
    endtask

    task automatic test_ws0;
        logic [31:0] rd; logic e;
        int acc;
        do_req(1, 1'b1, 32'h1008, 32'hCAFE_F00D, 4'hF, 0, rd, e);
        do_req(1, 1'b0, 32'h1008, 32'h0, 4'h0, 2, rd, e);
        n_chk++;
        if (rd !== 32'hCAFE_F00D) $display("FAIL ws0_load: got %h expected cafef00d", rd);
        else n_pass++;
        do_req(1, 1'b0, 32'h0FFC, 32'h0, 4'h0, 0, rd, e);

        @(negedge clk);
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h1008; rsp_ready[1] = 1'b1;
        acc = 0;
        for (int k = 0; k < 12; k++) begin
            if (req_ready[1] === 1'b1) begin
                acc++;
            end else begin
                n_chk++;
                if (rsp_rdata[1] !== mm[1][2]) $display("FAIL stream_rdata k=%0d: got %h expected %h", k, rsp_rdata[1], mm[1][2]);
                else n_pass++;
            end
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        n_chk++;
        if (acc != 6) $display("FAIL stream_accepts: got %0d expected 6", acc);
        else n_pass++;
        @(negedge clk);
        n_chk++;
        if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0)
            $display("FAIL stream_drain: got rdy=%b v=%b expected 1 0", req_ready[1], rsp_valid[1]);
        else n_pass++;
        rsp_ready[1] = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] rd, addr; logic e;
        int d, r;
        longint b, dp;
        for (int n = 0; n < 80; n++) begin
            d = n % 2;
            b = base_of(d);
            dp = dep_of(d);
            r = $urandom_range(0, 9);
            if (r < 7)       addr = 32'(b + 4 * $urandom_range(0, int'(dp) - 1));
            else if (r == 7) addr = 32'(b + $urandom_range(0, int'(dp) * 4 - 1)) | 32'h1;
            else if (r == 8) addr = (d == 1) ? 32'($urandom_range(0, 32'hFFF)) : 32'(b + dp * 4 + $urandom_range(0, 4096));
            else             addr = 32'hFFFF_FFFC;
            do_req(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
                   $urandom_range(0, 2), rd, e);
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = 32'd0;
            req_wdata[d] = 32'd0; req_be[d] = 4'd0; rsp_ready[d] = 1'b0;
        end
        test_reset;
        test_prefill;
        test_store_load;
        test_partial;
        test_errors;
        test_hold;
        test_reset_mid_wait;
        test_ws0;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
